ram_host_arbiter: RTL and testbench
===================================

// Module: ram_host_arbiter
// PURPOSE
//  Shares the sample/coefficient data RAM between the SRC controller core and a host coefficient-load port.
//  Host bursts are granted only at an instruction boundary: core parked in S8 via its en input.
//  Core access is muxed through to RAM ports A/B; the host owns port A only during its burst.
//  Fairness: after each host burst the core completes at least one full instruction (S1..S8) before the next grant.
// PARAMETERS
//  DATA_W       24                        RAM word width
//  DATA_ADDR_W  CtrlUnit::DATA_ADDR_W     RAM address width
//  MAX_BURST    64                        max host words per grant
//  LEN_W        $clog2(MAX_BURST+1)       derived, host_len width
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, synchronous, active-low
//  core_en_in   in   1            global run enable from top level
//  core_en      out  1            en to controller core
//  core_state   in   TState       controller current state
//  core_en_a/b  in   1            core RAM port A/B enable
//  core_we_a/b  in   1            core RAM port A/B write
//  core_addr_a/b in  DATA_ADDR_W  core RAM addresses
//  core_wdata_a in   DATA_W       core port A write data
//  host_req     in   1            burst request; held high until host_done
//  host_we      in   1            1 = write burst, 0 = read burst (latched at grant)
//  host_addr    in   DATA_ADDR_W  burst start address (latched at grant)
//  host_len     in   LEN_W        burst length 1..MAX_BURST (latched at grant)
//  host_wdata   in   DATA_W       write beat data
//  host_wvalid  in   1            write beat valid
//  host_wready  out  1            write beat accepted when wvalid & wready
//  host_rdata   out  DATA_W       read data
//  host_rvalid  out  1            read data valid, one pulse per word
//  host_done    out  1            one-cycle pulse, burst complete
//  ram_en_a/b, ram_we_a/b  out 1            RAM port controls
//  ram_addr_a/b            out DATA_ADDR_W  RAM addresses
//  ram_wdata_a             out DATA_W       RAM port A write data
//  ram_rdata_a             in  DATA_W       RAM port A read data, 1-cycle latency
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE, beat counter 0, core_ran=1.
//   host_wready/rvalid/done = 0, host_rdata = 0. core_en follows core_en_in.
//  FSM states IDLE, PEND, HOST, DRAIN.
//  IDLE
//   - RAM ports = core signals, pass-through combinationally.
//   - host_req & core_ran -> PEND.
//  PEND
//   - Pass-through continues.
//   - core_en = core_en_in & (core_state != S8): combinational, so the core holds in S8.
//   - core_state == S8 -> HOST; latch host_we/addr/len; clear counter and core_ran.
//  HOST
//   - core_en = 0; port B forced idle (en=0, we=0).
//   - Write: host_wready = 1; each accepted beat drives ram_en_a = we_a = 1.
//     ram_addr_a = addr_l + cnt, wrapping mod 2^DATA_ADDR_W; cnt++.
//   - Read: one ram_en_a per cycle at addr_l + cnt.
//     host_rvalid/rdata registered, 1 cycle after each issue.
//   - Last beat (cnt == len_l - 1) -> DRAIN.
//   - host_len == 0 is treated as 1.
//  DRAIN (1 cycle)
//   - core_en = 0; last read word delivered.
//   - host_done pulses; -> IDLE. core_en is restored in IDLE.
//  core_ran is set in IDLE when core_state != S8, so a new grant needs the core to leave S8 and return.
//  core_en_in = 0 in PEND: core is already stopped, so the grant proceeds once state is S8. core_en_in has no effect in HOST.
//  host_req dropped before grant: PEND -> IDLE. host_req dropped inside HOST: ignored, burst completes.
//  Reset mid-burst: immediate IDLE; written words persist; no host_done.
//  Latency: grant <= 1 instruction + 1 cycle; write burst N = N beats + 1; read burst N = N + 1 cycles.
// STRUCTURE
//  CtrlUnit package: TState (used), DATA_ADDR_W, new enum TArbState {IDLE, PEND, HOST, DRAIN}.
//  Single module. Port mux is an always_comb on state; FSM and counter in one always_ff.
// TESTING
//  1. Core free-running, host_req=0 -> ram_* mirror core_* every cycle; core_en == core_en_in.
//  2. Write burst: host_addr=0x3FE, len=4, wvalid always 1.
//     -> core held in S8; writes at 0x3FE,0x3FF,0x000,0x001; host_done 1 cycle after 4th beat.
//  3. Read burst: len=3 from 0x010 after test 2 -> rvalid x3 with matching data; core resumes at S1 after done.
//  4. host_req held continuously -> core runs a full S1..S8 instruction between consecutive grants.
//  5. rst=0 during 2nd beat of a len=8 write -> next cycle IDLE, core_en=core_en_in, no host_done.
//     Beat 1 data is present in RAM.
//  6. Write burst with wvalid toggling 1,0,1,0 -> only 1-cycles counted; ram_we_a only on accepted beats.

Source files
------------

// File: rtl/ram_host_arbiter_pkg.sv
// Shared controller types: core sequencer states, data RAM geometry and the
// host/core RAM arbiter states.
package CtrlUnit;

    localparam int unsigned DATA_ADDR_W = 10;

    // One controller instruction walks S1..S8; S8 is the instruction boundary.
    typedef enum logic [2:0] {
        S1, S2, S3, S4, S5, S6, S7, S8
    } TState;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOST,
        DRAIN
    } TArbState;

endpackage

// File: rtl/ram_host_arbiter.sv
// Shares the sample/coefficient data RAM between the controller core and a host
// burst port; host bursts are granted only while the core is parked in S8.
module ram_host_arbiter
    import CtrlUnit::*;
#(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned DATA_ADDR_W = CtrlUnit::DATA_ADDR_W,
    parameter int unsigned MAX_BURST   = 64,
    parameter int unsigned LEN_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   core_en_in_i,
    output logic                   core_en_o,
    input  TState                  core_state_i,
    input  logic                   core_en_a_i,
    input  logic                   core_en_b_i,
    input  logic                   core_we_a_i,
    input  logic                   core_we_b_i,
    input  logic [DATA_ADDR_W-1:0] core_addr_a_i,
    input  logic [DATA_ADDR_W-1:0] core_addr_b_i,
    input  logic [DATA_W-1:0]      core_wdata_a_i,

    input  logic                   host_req_i,
    input  logic                   host_we_i,
    input  logic [DATA_ADDR_W-1:0] host_addr_i,
    input  logic [LEN_W-1:0]       host_len_i,
    input  logic [DATA_W-1:0]      host_wdata_i,
    input  logic                   host_wvalid_i,
    output logic                   host_wready_o,
    output logic [DATA_W-1:0]      host_rdata_o,
    output logic                   host_rvalid_o,
    output logic                   host_done_o,

    output logic                   ram_en_a_o,
    output logic                   ram_en_b_o,
    output logic                   ram_we_a_o,
    output logic                   ram_we_b_o,
    output logic [DATA_ADDR_W-1:0] ram_addr_a_o,
    output logic [DATA_ADDR_W-1:0] ram_addr_b_o,
    output logic [DATA_W-1:0]      ram_wdata_a_o,
    input  logic [DATA_W-1:0]      ram_rdata_a_i
);

    TArbState               state_q, state_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0]       len_l_q, len_l_d;
    logic [DATA_ADDR_W-1:0] addr_l_q, addr_l_d;
    logic                   we_l_q, we_l_d;
    logic                   core_ran_q, core_ran_d;
    logic                   rvalid_q, rvalid_d;

    logic                   host_beat;
    logic [DATA_ADDR_W-1:0] host_addr_cur;

    // Reads issue every HOST cycle; writes only on accepted beats.
    assign host_beat     = we_l_q ? host_wvalid_i : 1'b1;
    // Address arithmetic wraps naturally at the RAM address width.
    assign host_addr_cur = addr_l_q + DATA_ADDR_W'(cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_l_d    = len_l_q;
        addr_l_d   = addr_l_q;
        we_l_d     = we_l_q;
        core_ran_d = core_ran_q;
        rvalid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (core_state_i != S8) begin
                    core_ran_d = 1'b1;
                end
                if (host_req_i && core_ran_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                end else if (core_state_i == S8) begin
                    state_d    = HOST;
                    we_l_d     = host_we_i;
                    addr_l_d   = host_addr_i;
                    len_l_d    = (host_len_i == '0) ? LEN_W'(1) : host_len_i;
                    cnt_d      = '0;
                    core_ran_d = 1'b0;
                end
            end
            HOST: begin
                rvalid_d = !we_l_q;
                if (host_beat) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_l_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_l_q    <= LEN_W'(1);
            addr_l_q   <= '0;
            we_l_q     <= 1'b0;
            core_ran_q <= 1'b1;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_l_q    <= len_l_d;
            addr_l_q   <= addr_l_d;
            we_l_q     <= we_l_d;
            core_ran_q <= core_ran_d;
            rvalid_q   <= rvalid_d;
        end
    end

    always_comb begin
        core_en_o     = core_en_in_i;
        host_wready_o = 1'b0;
        host_done_o   = 1'b0;
        ram_en_a_o    = core_en_a_i;
        ram_we_a_o    = core_we_a_i;
        ram_addr_a_o  = core_addr_a_i;
        ram_wdata_a_o = core_wdata_a_i;
        ram_en_b_o    = core_en_b_i;
        ram_we_b_o    = core_we_b_i;
        ram_addr_b_o  = core_addr_b_i;

        unique case (state_q)
            IDLE: begin
            end
            PEND: begin
                // Freeze the core as soon as it reaches the instruction boundary.
                core_en_o = core_en_in_i && (core_state_i != S8);
            end
            HOST: begin
                core_en_o     = 1'b0;
                ram_en_b_o    = 1'b0;
                ram_we_b_o    = 1'b0;
                ram_addr_a_o  = host_addr_cur;
                ram_wdata_a_o = host_wdata_i;
                if (we_l_q) begin
                    host_wready_o = 1'b1;
                    ram_en_a_o    = host_wvalid_i;
                    ram_we_a_o    = host_wvalid_i;
                end else begin
                    ram_en_a_o    = 1'b1;
                    ram_we_a_o    = 1'b0;
                end
            end
            DRAIN: begin
                core_en_o   = 1'b0;
                host_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The RAM output is already registered; gate it so rdata reads 0 between words.
    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = rvalid_q ? ram_rdata_a_i : '0;

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed bench for ram_host_arbiter with a port-A RAM model and a simple
// S1..S8 core sequencer model.
module tb_ram_host_arbiter;
    import CtrlUnit::*;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 10;
    localparam int unsigned LW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_init;
    logic          core_en_in, core_en;
    TState         core_state;
    logic          core_en_a, core_en_b, core_we_a, core_we_b;
    logic [AW-1:0] core_addr_a, core_addr_b;
    logic [DW-1:0] core_wdata_a;
    logic          host_req, host_we, host_wvalid, host_wready, host_rvalid, host_done;
    logic [AW-1:0] host_addr;
    logic [LW-1:0] host_len;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          ram_en_a, ram_en_b, ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_wdata_a, ram_rdata_a;
    logic [DW-1:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    ram_host_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .core_en_in_i  (core_en_in),
        .core_en_o     (core_en),
        .core_state_i  (core_state),
        .core_en_a_i   (core_en_a),
        .core_en_b_i   (core_en_b),
        .core_we_a_i   (core_we_a),
        .core_we_b_i   (core_we_b),
        .core_addr_a_i (core_addr_a),
        .core_addr_b_i (core_addr_b),
        .core_wdata_a_i(core_wdata_a),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_len_i    (host_len),
        .host_wdata_i  (host_wdata),
        .host_wvalid_i (host_wvalid),
        .host_wready_o (host_wready),
        .host_rdata_o  (host_rdata),
        .host_rvalid_o (host_rvalid),
        .host_done_o   (host_done),
        .ram_en_a_o    (ram_en_a),
        .ram_en_b_o    (ram_en_b),
        .ram_we_a_o    (ram_we_a),
        .ram_we_b_o    (ram_we_b),
        .ram_addr_a_o  (ram_addr_a),
        .ram_addr_b_o  (ram_addr_b),
        .ram_wdata_a_o (ram_wdata_a),
        .ram_rdata_a_i (ram_rdata_a)
    );

    // Port-A RAM, 1-cycle read latency; preset to 0x5A0000 | addr.
    always_ff @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 24'h5A0000 | 24'(i);
            ram_rdata_a <= '0;
        end else if (ram_en_a) begin
            if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
            else          ram_rdata_a     <= mem[ram_addr_a];
        end
    end

    // Core sequencer: advances one state per enabled cycle, S8 wraps to S1.
    always_ff @(posedge clk) begin
        if (mem_init)     core_state <= S1;
        else if (core_en) core_state <= TState'(core_state + 3'd1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wready(input string tag);
        int g = 0;
        while (host_wready !== 1'b1 && g < 40) begin
            cyc();
            g++;
        end
        check_eq(tag, 64'(host_wready), 64'd1);
    endtask

    logic [AW-1:0] t2_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [DW-1:0] t2_data [4] = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004};
    logic [DW-1:0] t3_data [3] = '{24'h5A0010, 24'h5A0011, 24'h5A0012};
    logic          t6_wv   [3] = '{1'b1, 1'b0, 1'b1};
    logic [DW-1:0] t6_data [3] = '{24'hC00001, 24'hDEAD00, 24'hC00002};
    logic [AW-1:0] t6_addr [3] = '{10'h200, 10'h201, 10'h201};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, g, adv;
        logic seen_done;
        logic [31:0] r;

        mem_init = 1'b1;
        rst = 1'b0;
        core_en_in = 1'b1;
        {core_en_a, core_en_b, core_we_a, core_we_b} = '0;
        core_addr_a = '0; core_addr_b = '0; core_wdata_a = '0;
        {host_req, host_we, host_wvalid} = '0;
        host_addr = '0; host_len = '0; host_wdata = '0;
        repeat (3) cyc();
        mem_init = 1'b0;

        // Reset state
        check_eq("rst_wready", 64'(host_wready), 64'd0);
        check_eq("rst_rvalid", 64'(host_rvalid), 64'd0);
        check_eq("rst_done",   64'(host_done),   64'd0);
        check_eq("rst_rdata",  64'(host_rdata),  64'd0);
        check_eq("rst_core_en", 64'(core_en),    64'd1);
        core_en_in = 1'b0;
        #1;
        check_eq("rst_core_en_off", 64'(core_en), 64'd0);
        rst = 1'b1;
        core_en_in = 1'b1;

        // Test 1: pass-through while no host request
        for (int i = 0; i < 8; i++) begin
            cyc();
            r = $urandom;
            core_en_a    = r[0];
            core_we_a    = r[1];
            core_en_b    = r[2];
            core_we_b    = r[3];
            core_en_in   = r[4];
            core_addr_a  = 10'h300 | AW'(r[15:8]);
            core_addr_b  = AW'(r[25:16]);
            core_wdata_a = 24'h330000 | DW'(r[7:0]);
            #1;
            check_eq("t1_port_a", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a},
                     {core_en_a, core_we_a, core_addr_a, core_wdata_a});
            check_eq("t1_port_b", {ram_en_b, ram_we_b, ram_addr_b},
                     {core_en_b, core_we_b, core_addr_b});
            check_eq("t1_core_en", 64'(core_en), 64'(core_en_in));
        end
        core_en_in = 1'b1;
        core_en_a = 1'b1; core_we_a = 1'b0; core_addr_a = 10'h0F0;
        core_en_b = 1'b1; core_we_b = 1'b0; core_addr_b = 10'h0F1;

        // Test 2: write burst wrapping the address space
        cyc();
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h3FE; host_len = 7'd4;
        host_wvalid = 1'b1; host_wdata = t2_data[0];
        wait_wready("t2_grant");
        check_eq("t2_core_s8", 64'(core_state), 64'(S8));
        for (int b = 0; b < 4; b++) begin
            host_wdata = t2_data[b];
            #1;
            check_eq("t2_ram_a", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a},
                     {1'b1, 1'b1, t2_addr[b], t2_data[b]});
            check_eq("t2_port_b_idle", {ram_en_b, ram_we_b}, 2'b00);
            check_eq("t2_core_held", {core_en, core_state}, {1'b0, S8});
            check_eq("t2_no_done", 64'(host_done), 64'd0);
            cyc();
        end
        check_eq("t2_done", 64'(host_done), 64'd1);
        check_eq("t2_drain_core_en", 64'(core_en), 64'd0);
        host_req = 1'b0; host_wvalid = 1'b0;
        cyc();
        check_eq("t2_done_pulse", 64'(host_done), 64'd0);
        check_eq("t2_core_en_back", 64'(core_en), 64'd1);
        for (int b = 0; b < 4; b++) check_eq("t2_mem", 64'(mem[t2_addr[b]]), 64'(t2_data[b]));

        // Test 3: read burst
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010; host_len = 7'd3;
        k = 0; seen_done = 1'b0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            if (host_rvalid) begin
                if (k < 3) check_eq("t3_rdata", 64'(host_rdata), 64'(t3_data[k]));
                k++;
            end
            if (host_done) seen_done = 1'b1;
            else cyc();
        end
        check_eq("t3_done_seen", 64'(seen_done), 64'd1);
        check_eq("t3_rvalid_count", 64'(k), 64'd3);
        check_eq("t3_rvalid_at_done", 64'(host_rvalid), 64'd1);
        host_req = 1'b0;
        cyc();
        check_eq("t3_rvalid_off", 64'(host_rvalid), 64'd0);
        check_eq("t3_idle_core", {core_en, core_state}, {1'b1, S8});
        cyc();
        check_eq("t3_resume_s1", 64'(core_state), 64'(S1));

        // Test 4: back-to-back requests, core must run a full instruction between
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h020; host_len = 7'd1;
        host_wvalid = 1'b1; host_wdata = 24'hB00020;
        wait_wready("t4_grant1");
        cyc();
        check_eq("t4_done1", 64'(host_done), 64'd1);
        host_addr = 10'h021; host_wdata = 24'hB00021;
        adv = 0; g = 0;
        while (host_wready !== 1'b1 && g < 40) begin
            if (core_en) adv++;
            cyc();
            g++;
        end
        check_eq("t4_core_advances", 64'(adv), 64'd8);
        check_eq("t4_grant_latency", 64'(g), 64'd10);
        check_eq("t4_core_s8", 64'(core_state), 64'(S8));
        cyc();
        check_eq("t4_done2", 64'(host_done), 64'd1);
        host_req = 1'b0; host_wvalid = 1'b0;
        cyc();
        check_eq("t4_mem0", 64'(mem[10'h020]), 64'h00B00020);
        check_eq("t4_mem1", 64'(mem[10'h021]), 64'h00B00021);

        // Test 5: reset during the second beat of a len=8 write
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h100; host_len = 7'd8;
        host_wvalid = 1'b1; host_wdata = 24'h111111;
        wait_wready("t5_grant");
        cyc();
        rst = 1'b0; host_wdata = 24'h222222;
        cyc();
        check_eq("t5_no_done", 64'(host_done), 64'd0);
        check_eq("t5_wready_off", 64'(host_wready), 64'd0);
        check_eq("t5_core_en", 64'(core_en), 64'd1);
        check_eq("t5_port_b_back", {ram_en_b, ram_addr_b}, {1'b1, 10'h0F1});
        rst = 1'b1; host_req = 1'b0; host_wvalid = 1'b0;
        cyc();
        check_eq("t5_no_done_after", 64'(host_done), 64'd0);
        check_eq("t5_beat1_mem", 64'(mem[10'h100]), 64'h00111111);

        // Test 6: gapped write beats
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'h200; host_len = 7'd2;
        host_wvalid = 1'b1; host_wdata = t6_data[0];
        wait_wready("t6_grant");
        for (int i = 0; i < 3; i++) begin
            host_wvalid = t6_wv[i];
            host_wdata  = t6_data[i];
            #1;
            check_eq("t6_ram_a", {ram_en_a, ram_we_a, ram_addr_a},
                     {t6_wv[i], t6_wv[i], t6_addr[i]});
            check_eq("t6_no_done", 64'(host_done), 64'd0);
            cyc();
        end
        check_eq("t6_done", 64'(host_done), 64'd1);
        host_req = 1'b0; host_wvalid = 1'b0;
        cyc();
        check_eq("t6_mem0", 64'(mem[10'h200]), 64'h00C00001);
        check_eq("t6_mem1", 64'(mem[10'h201]), 64'h00C00002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
